// File: rtl/adc_frame_seq_pkg.sv
// Shared state encoding, timeout fill value and default sizing for the ADC frame sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CONV   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4,
        ST_NEXT   = 3'd5
    } state_e;

    localparam logic [9:0] TIMEOUT_VAL = 10'h3FF;

    localparam int DEF_ROWS        = 32'sd16;
    localparam int DEF_COLS        = 32'sd16;
    localparam int DEF_SETTLE_CYC  = 32'sd4;
    localparam int DEF_TIMEOUT_CYC = 32'sd64;

    // A single row or column still needs a 1-bit address bus.
    function automatic int addr_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_frame_seq_cycle_timer.sv
// Loadable down-counter; expired pulses in the last cycle of the loaded interval.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/adc_frame_seq.sv
// Pixel-array ADC scan sequencer feeding a downstream SIPO.
// Build option: ADC_FRAME_SEQ_TEST_PATTERN_EN replaces pixel data with a per-frame pixel counter.
module adc_frame_seq
    import adc_seq_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      cont_mode,
    output logic                      adc_conv,
    input  logic                      adc_valid,
    input  logic [9:0]                adc_data,
    output logic [addr_w(ROWS)-1:0]   row_addr,
    output logic [addr_w(COLS)-1:0]   col_addr,
    output logic                      SIPO_en,
    output logic [9:0]                SIPO_in,
    output logic                      force_rdy,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err
);

    localparam int RW = addr_w(ROWS);
    localparam int CW = addr_w(COLS);
    localparam int TW = $clog2(max2(SETTLE_CYC, TIMEOUT_CYC) + 32'sd1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [9:0]      data_q, data_d;
    logic            err_q, err_d;
    logic            stop_pend_q, stop_pend_d;
    logic            adc_conv_q, adc_conv_d;
    logic            sipo_en_q, sipo_en_d;
    logic [9:0]      sipo_in_q, sipo_in_d;
    logic            force_rdy_q, force_rdy_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            last_col_s, last_row_s, last_pix_s, stop_seen_s;
    logic            tmr_load_s, tmr_expired_s;
    logic [TW-1:0]   tmr_val_s;
    logic [9:0]      emit_val_s;

    assign last_col_s  = (col_q == CW'(COLS - 1));
    assign last_row_s  = (row_q == RW'(ROWS - 1));
    assign last_pix_s  = last_col_s & last_row_s;
    // A stop arriving in the very last NEXT cycle must still end the scan.
    assign stop_seen_s = stop_pend_q | (busy_q & stop);

    // Scan FSM: next state, pixel addressing, captured sample and sticky error.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_expired_s) begin
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CONV: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (adc_valid) begin
                    data_d  = adc_data;
                    state_d = ST_EMIT;
                end else if (tmr_expired_s) begin
                    data_d  = TIMEOUT_VAL;
                    err_d   = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EMIT: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (!last_col_s) begin
                    col_d   = col_q + CW'(1);
                    state_d = ST_CONV;
                end else if (!last_row_s) begin
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    state_d = ST_SETTLE;
                end else begin
                    col_d = '0;
                    row_d = '0;
                    if (cont_mode && !stop_seen_s) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending stop: set while scanning, dropped whenever the FSM lands in IDLE.
    always_comb begin
        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end else if (busy_q && stop) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end
    end

    // One timer serves both SETTLE and WAIT, reloaded on entry to either.
    always_comb begin
        tmr_load_s = (state_d != state_q) && ((state_d == ST_SETTLE) || (state_d == ST_WAIT));
        if (state_d == ST_WAIT) begin
            tmr_val_s = TW'(TIMEOUT_CYC);
        end else begin
            tmr_val_s = TW'(SETTLE_CYC);
        end
    end

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expired  (tmr_expired_s)
    );

`ifdef ADC_FRAME_SEQ_TEST_PATTERN_EN
    logic [9:0] pix_q, pix_d;

    // Pattern counter: zero at each frame start, one step per emitted pixel.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            pix_d = 10'd0;
        end else if (state_q == ST_NEXT) begin
            if (last_pix_s) begin
                pix_d = 10'd0;
            end else begin
                pix_d = pix_q + 10'd1;
            end
        end else begin
            pix_d = pix_q;
        end
    end

    // Pattern counter register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            pix_q <= 10'd0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign emit_val_s = pix_q;
`else
    assign emit_val_s = data_q;
`endif

    // Output strobes decoded from the current state, so they trail it by one cycle.
    always_comb begin
        adc_conv_d   = (state_q == ST_CONV);
        sipo_en_d    = (state_q == ST_EMIT);
        force_rdy_d  = (state_q == ST_EMIT) && last_pix_s;
        frame_done_d = (state_q == ST_NEXT) && last_pix_s;
        busy_d       = (state_d != ST_IDLE);
        if (state_q == ST_EMIT) begin
            sipo_in_d = emit_val_s;
        end else begin
            sipo_in_d = 10'd0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            data_q       <= 10'd0;
            err_q        <= 1'b0;
            stop_pend_q  <= 1'b0;
            adc_conv_q   <= 1'b0;
            sipo_en_q    <= 1'b0;
            sipo_in_q    <= 10'd0;
            force_rdy_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            data_q       <= data_d;
            err_q        <= err_d;
            stop_pend_q  <= stop_pend_d;
            adc_conv_q   <= adc_conv_d;
            sipo_en_q    <= sipo_en_d;
            sipo_in_q    <= sipo_in_d;
            force_rdy_q  <= force_rdy_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign adc_conv   = adc_conv_q;
    assign row_addr   = row_q;
    assign col_addr   = col_q;
    assign SIPO_en    = sipo_en_q;
    assign SIPO_in    = sipo_in_q;
    assign force_rdy  = force_rdy_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_adc_frame_seq.sv
// Scoreboard bench for adc_frame_seq on a 2x3 array: an ADC model answers each conversion
// and pushes the expected pixel; a monitor pops and compares on every SIPO_en.
module tb_adc_frame_seq;

    localparam int ROWS   = 2;
    localparam int COLS   = 3;
    localparam int SETTLE = 4;
    localparam int TOUT   = 64;
    localparam int NPIX   = ROWS * COLS;

    typedef struct {
        int         row;
        int         col;
        logic [9:0] val;
        logic       frc;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst, start, stop, cont_mode, adc_valid;
    logic [9:0] adc_data;
    logic       adc_conv, SIPO_en, force_rdy, busy, frame_done, err;
    logic [0:0] row_addr;
    logic [1:0] col_addr;
    logic [9:0] SIPO_in;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, cyc = 0;
    int   sipo_cnt = 0, force_cnt = 0, done_cnt = 0;
    int   exp_pix = 0, withhold = -1, resp_cnt = 0, last_conv_cyc = 0, exp_gap = 0;
    bit   first_conv = 1'b1, prev_frc = 1'b0;
    logic [9:0] resp_val;
    int   s0, f0, d0;

    adc_frame_seq #(.ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .nrst(nrst), .start(start), .stop(stop), .cont_mode(cont_mode),
        .adc_conv(adc_conv), .adc_valid(adc_valid), .adc_data(adc_data),
        .row_addr(row_addr), .col_addr(col_addr), .SIPO_en(SIPO_en), .SIPO_in(SIPO_in),
        .force_rdy(force_rdy), .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start();
        first_conv = 1'b1;
        exp_pix    = 0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check("idle_reached", busy, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_sipo(input int n, input int budget);
        for (int i = 0; i < budget && sipo_cnt < n; i++) tick();
        check("sipo_reached", (sipo_cnt >= n), 1);
    endtask

    // ADC model: answers 3 cycles after adc_conv unless the pixel is withheld.
    initial begin
        exp_t e;
        int   k;
        adc_valid = 1'b0;
        adc_data  = 10'd0;
        forever begin
            tick();
            adc_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    adc_valid = 1'b1;
                    adc_data  = resp_val;
                end
            end
            if (adc_conv) begin
                k = exp_pix;
                if (!first_conv) check("conv_gap", cyc - last_conv_cyc, exp_gap);
                first_conv    = 1'b0;
                last_conv_cyc = cyc;
                exp_gap = ((k == withhold) ? TOUT + 3 : 7) + (((k + 1) % COLS == 0) ? SETTLE : 0);
                e.row = k / COLS;
                e.col = k % COLS;
                e.frc = (k == NPIX - 1);
                if (k == withhold) begin
                    e.val = 10'h3FF;
                    e.cyc = cyc + TOUT + 1;
                end else begin
                    resp_val = 10'(32'h100 + k);
                    resp_cnt = 3;
                    e.val    = resp_val;
                    e.cyc    = cyc + 5;
                end
`ifdef ADC_FRAME_SEQ_TEST_PATTERN_EN
                e.val = 10'(k);
`endif
                sb.push_back(e);
                exp_pix = (k + 1) % NPIX;
            end
        end
    end

    // Monitor: pops the scoreboard on SIPO_en and tracks strobe counts.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (SIPO_en) begin
                sipo_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sipo_in", SIPO_in, e.val);
                    check("force_rdy", force_rdy, e.frc);
                    check("row_addr", row_addr, e.row);
                    check("col_addr", col_addr, e.col);
                    check("sipo_latency", cyc, e.cyc);
                end
            end else if (force_rdy) begin
                check("force_stray", force_rdy, 0);
            end
            if (force_rdy) force_cnt++;
            if (frame_done) begin
                done_cnt++;
                check("done_after_force", prev_frc, 1);
            end
            prev_frc = force_rdy;
        end
    end

    initial begin
        nrst = 1'b0; start = 1'b0; stop = 1'b0; cont_mode = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_conv", adc_conv, 0);
        check("rst_sipo_en", SIPO_en, 0);
        check("rst_sipo_in", SIPO_in, 0);
        check("rst_force", force_rdy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_row", row_addr, 0);
        check("rst_col", col_addr, 0);
        nrst = 1'b1;
        tick();

        // Single frame, normal ADC responses.
        s0 = sipo_cnt; f0 = force_cnt; d0 = done_cnt;
        run_start();
        wait_idle(400);
        check("A_pixels", sipo_cnt - s0, NPIX);
        check("A_force", force_cnt - f0, 1);
        check("A_done", done_cnt - d0, 1);
        check("A_err", err, 0);

        // Continuous mode with stop during pixel 2: frame completes, no second frame.
        cont_mode = 1'b1;
        s0 = sipo_cnt; f0 = force_cnt; d0 = done_cnt;
        run_start();
        wait_sipo(s0 + 2, 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(400);
        check("B_pixels", sipo_cnt - s0, NPIX);
        check("B_done", done_cnt - d0, 1);
        cont_mode = 1'b0;

        // ADC silent on pixel 4: timeout fill, sticky err.
        withhold = 4;
        s0 = sipo_cnt; f0 = force_cnt; d0 = done_cnt;
        run_start();
        wait_idle(600);
        check("C_pixels", sipo_cnt - s0, NPIX);
        check("C_err_set", err, 1);
        repeat (5) tick();
        check("C_err_held", err, 1);
        withhold = -1;

        // Reset during pixel 3, then a clean frame from (0,0).
        s0 = sipo_cnt; f0 = force_cnt; d0 = done_cnt;
        run_start();
        check("D_err_cleared", err, 0);
        wait_sipo(s0 + 3, 200);
        nrst = 1'b0;
        tick();
        check("D_rst_busy", busy, 0);
        check("D_rst_conv", adc_conv, 0);
        check("D_rst_sipo", SIPO_en, 0);
        check("D_rst_col", col_addr, 0);
        @(posedge clk);
        #2;
        sb.delete();
        resp_cnt  = 0;
        adc_valid = 1'b0;
        exp_pix   = 0;
        nrst      = 1'b1;
        tick();
        check("D_no_done", done_cnt - d0, 0);
        check("D_no_force", force_cnt - f0, 0);
        s0 = sipo_cnt;
        run_start();
        wait_idle(400);
        check("D_pixels", sipo_cnt - s0, NPIX);
        check("D_done", done_cnt - d0, 1);

        // Three back-to-back frames in continuous mode; stop during the third.
        cont_mode = 1'b1;
        s0 = sipo_cnt; f0 = force_cnt; d0 = done_cnt;
        run_start();
        for (int i = 0; i < 600 && done_cnt < d0 + 2; i++) tick();
        check("E_two_frames", (done_cnt >= d0 + 2), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(400);
        check("E_pixels", sipo_cnt - s0, 3 * NPIX);
        check("E_force", force_cnt - f0, 3);
        check("E_done", done_cnt - d0, 3);
        cont_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
